// File: rtl/avmm_arb_pkg.sv
// Shared types and defaults for the two-port Avalon-MM read arbiter.
// Optional build macro used by this slice: AUDIO_PRIORITY_EN (see avmm_rr_arbiter_2).
package avmm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DATA,
    DONE
  } arb_state_t;

  localparam int unsigned ADDR_W_DEF       = 27;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned MAX_LOCK_TXN_DEF = 16;

endpackage

// File: rtl/avmm_rr_arbiter_2.sv
// Two-requester grant selector used in the IDLE state of the read arbiter.
// Default build: lock holder wins if it requests, otherwise round-robin on ties.
// AUDIO_PRIORITY_EN defined: port 1 (audio) wins every tie and overrides a
// port-0 lock; last_grant is ignored.
module avmm_rr_arbiter_2
  import avmm_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       lock_owner_i,
  input  logic       lock_valid_i,
  output logic       gnt_valid_o,
  output logic       gnt_o
);

  // Grant index for the current request vector
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_o       = 1'b0;
`ifdef AUDIO_PRIORITY_EN
    // Port 1 requesting always wins, which also covers its own lock and
    // overrides any port-0 lock.
    gnt_o = req_i[1];
`else
    if (lock_valid_i && req_i[lock_owner_i]) begin
      gnt_o = lock_owner_i;
    end else if (req_i == 2'b11) begin
      gnt_o = ~last_grant_i;
    end else begin
      gnt_o = req_i[1];
    end
`endif
  end

endmodule

// File: rtl/avmm_read_arbiter_2to1.sv
// Shares one Avalon-MM read master between port 0 (video fetch) and port 1
// (audio fetch). One read outstanding downstream; round-robin with lock
// pass-through. Build macro AUDIO_PRIORITY_EN selects fixed audio priority.
module avmm_read_arbiter_2to1
  import avmm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned MAX_LOCK_TXN = MAX_LOCK_TXN_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  // port 0 (video)
  input  logic [ADDR_W-1:0] s0_address,
  input  logic              s0_read,
  input  logic              s0_lock,
  output logic              s0_waitrequest,
  output logic [DATA_W-1:0] s0_readdata,
  output logic              s0_readdatavalid,
  // port 1 (audio)
  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_read,
  input  logic              s1_lock,
  output logic              s1_waitrequest,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,
  // downstream master
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_lock,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid
);

  localparam int unsigned      CNT_W     = $clog2(MAX_LOCK_TXN + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK_TXN - 1);

  arb_state_t        state_q;
  logic              grant_q;
  logic              last_grant_q;
  logic              lock_valid_q;
  logic              lock_owner_q;
  logic [CNT_W-1:0]  lock_cnt_q;
  logic              abandon_q;
  logic [ADDR_W-1:0] m_address_q;
  logic              m_read_q;
  logic              m_lock_q;
  logic [DATA_W-1:0] s0_rdata_q;
  logic [DATA_W-1:0] s1_rdata_q;
  logic [1:0]        rdv_q;

  logic [1:0]        req;
  logic              arb_valid;
  logic              arb_gnt;
  logic              req_granted;
  logic              lock_granted;
  logic              abandon_d;
  logic              cap_en;
  logic              deliver;

  assign req = {s1_read, s0_read};

  avmm_rr_arbiter_2 u_arb (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .lock_owner_i (lock_owner_q),
    .lock_valid_i (lock_valid_q),
    .gnt_valid_o  (arb_valid),
    .gnt_o        (arb_gnt)
  );

  // Per-transaction qualifiers: abandonment, data capture and delivery
  always_comb begin
    req_granted  = grant_q ? s1_read : s0_read;
    lock_granted = grant_q ? s1_lock : s0_lock;
    abandon_d    = abandon_q | ~req_granted;
    cap_en       = m_readdatavalid &&
                   ((state_q == ISSUE && !m_waitrequest) || state_q == DATA);
    deliver      = cap_en & ~abandon_d;
  end

  // Control FSM with registered downstream command outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      lock_cnt_q   <= '0;
      abandon_q    <= 1'b0;
      m_address_q  <= '0;
      m_read_q     <= 1'b0;
      m_lock_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // The lock window is exactly this one IDLE cycle; a lock that is
          // not taken up here restarts the consecutive-grant count.
          lock_valid_q <= 1'b0;
          if (lock_valid_q && !(arb_valid && arb_gnt == lock_owner_q)) begin
            lock_cnt_q <= '0;
          end
          if (arb_valid) begin
            grant_q     <= arb_gnt;
            m_address_q <= arb_gnt ? s1_address : s0_address;
            m_lock_q    <= arb_gnt ? s1_lock : s0_lock;
            m_read_q    <= 1'b1;
            abandon_q   <= 1'b0;
            state_q     <= ISSUE;
          end else begin
            m_lock_q <= 1'b0;
          end
        end
        ISSUE: begin
          abandon_q <= abandon_d;
          if (!m_waitrequest) begin
            m_read_q <= 1'b0;
            state_q  <= m_readdatavalid ? DONE : DATA;
          end
        end
        DATA: begin
          abandon_q <= abandon_d;
          if (m_readdatavalid) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          last_grant_q <= grant_q;
          state_q      <= IDLE;
          if (lock_granted && !abandon_q && lock_cnt_q < LOCK_LAST) begin
            lock_cnt_q   <= lock_cnt_q + 1'b1;
            lock_valid_q <= 1'b1;
            lock_owner_q <= grant_q;
          end else begin
            lock_cnt_q   <= '0;
            lock_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Return-data capture and one-cycle strobe to the granted port only
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s0_rdata_q <= '0;
      s1_rdata_q <= '0;
      rdv_q      <= '0;
    end else begin
      rdv_q <= '0;
      if (deliver) begin
        if (grant_q) begin
          s1_rdata_q <= m_readdata;
          rdv_q      <= 2'b10;
        end else begin
          s0_rdata_q <= m_readdata;
          rdv_q      <= 2'b01;
        end
      end
    end
  end

  assign s0_waitrequest   = s0_read & ~(state_q == DONE && grant_q == 1'b0);
  assign s1_waitrequest   = s1_read & ~(state_q == DONE && grant_q == 1'b1);
  assign s0_readdata      = s0_rdata_q;
  assign s1_readdata      = s1_rdata_q;
  assign s0_readdatavalid = rdv_q[0];
  assign s1_readdatavalid = rdv_q[1];
  assign m_address        = m_address_q;
  assign m_read           = m_read_q;
  assign m_lock           = m_lock_q;

endmodule

// File: tb/tb_avmm_read_arbiter_2to1.sv
// Scoreboard bench for avmm_read_arbiter_2to1: stimulus pushes expected
// command addresses and per-port data, a monitor pops and compares.
`timescale 1ns/1ps
module tb_avmm_read_arbiter_2to1;

  localparam int unsigned AW = 27;
  localparam int unsigned DW = 32;
  localparam int unsigned LK = 4;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] adr [2];
  logic [1:0]    rd = 2'b00;
  logic [1:0]    lk = 2'b00;
  logic          s0_wait, s1_wait, s0_rdv, s1_rdv;
  logic [DW-1:0] s0_rdata, s1_rdata;
  logic [AW-1:0] m_address;
  logic          m_read, m_lock;
  logic          m_wait = 1'b1;
  logic          m_rdv  = 1'b0;
  logic [DW-1:0] m_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_d0 [$];
  logic [DW-1:0] exp_d1 [$];
  logic [AW-1:0] exp_a  [$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  // downstream model configuration
  int ws   = 0;
  int lat  = 4;
  bit same = 1'b0;

  always #5 clock = ~clock;

  avmm_read_arbiter_2to1 #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .MAX_LOCK_TXN (LK)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .s0_address       (adr[0]),
    .s0_read          (rd[0]),
    .s0_lock          (lk[0]),
    .s0_waitrequest   (s0_wait),
    .s0_readdata      (s0_rdata),
    .s0_readdatavalid (s0_rdv),
    .s1_address       (adr[1]),
    .s1_read          (rd[1]),
    .s1_lock          (lk[1]),
    .s1_waitrequest   (s1_wait),
    .s1_readdata      (s1_rdata),
    .s1_readdatavalid (s1_rdv),
    .m_address        (m_address),
    .m_read           (m_read),
    .m_lock           (m_lock),
    .m_waitrequest    (m_wait),
    .m_readdata       (m_rdata),
    .m_readdatavalid  (m_rdv)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got unexpected event, expected none", name);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present one read on port p and hold it until the DONE handshake; read
  // stays asserted on return so a follow-up call is back-to-back.
  task automatic issue(input int p, input logic [AW-1:0] a, input logic l, input logic [DW-1:0] d);
    bit done = 1'b0;
    adr[p] = a;
    lk[p]  = l;
    rd[p]  = 1'b1;
    mem[a] = d;
    if (p == 0) exp_d0.push_back(d);
    else        exp_d1.push_back(d);
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clock);
      if ((p == 0 && !s0_wait) || (p == 1 && !s1_wait)) done = 1'b1;
    end
    if (!done) note_fail("issue_timeout");
    @(posedge clock);
    #1;
  endtask

  // Downstream slave model: ws stall cycles, then data lat cycles after
  // accept, or together with accept when same is set.
  initial begin
    int phase = 0;
    int cnt   = 0;
    int k     = 0;
    logic [AW-1:0] a_l = '0;
    forever begin
      @(posedge clock);
      #1;
      m_rdv = 1'b0;
      if (!reset_n) begin
        phase  = 0;
        m_wait = 1'b1;
      end else begin
        if (phase == 0 && m_read) begin
          cnt   = ws;
          phase = 1;
        end
        if (phase == 1) begin
          if (!m_read) begin
            phase  = 0;
            m_wait = 1'b1;
          end else if (cnt == 0) begin
            m_wait = 1'b0;
            a_l    = m_address;
            k      = lat;
            phase  = 2;
            if (same) begin
              m_rdv   = 1'b1;
              m_rdata = mem[a_l];
              phase   = 3;
            end
          end else begin
            m_wait = 1'b1;
            cnt--;
          end
        end else if (phase == 2) begin
          m_wait = 1'b1;
          k--;
          if (k <= 0) begin
            m_rdv   = 1'b1;
            m_rdata = mem[a_l];
            phase   = 0;
          end
        end else if (phase == 3) begin
          m_wait = 1'b1;
          phase  = 0;
        end
      end
    end
  end

  // Monitor: command order, m_read gap, per-port data and latency
  initial begin
    int cyc     = 0;
    int acc_cyc = 0;
    int exp_lat = 0;
    bit prev_acc = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (prev_acc) check("m_read_gap", m_read, 0);
      prev_acc = m_read && !m_wait;
      if (m_read && !m_wait) begin
        acc_cyc = cyc;
        exp_lat = same ? 1 : lat + 1;
        if (exp_a.size() == 0) note_fail("unexpected_cmd");
        else check("grant_addr", m_address, exp_a.pop_front());
      end
      if (s0_rdv && s1_rdv) note_fail("both_rdv");
      if (s0_rdv) begin
        if (exp_d0.size() == 0) note_fail("s0_unexpected_rdv");
        else begin
          check("s0_data", s0_rdata, exp_d0.pop_front());
          check("s0_latency", cyc - acc_cyc, exp_lat);
        end
      end
      if (s1_rdv) begin
        if (exp_d1.size() == 0) note_fail("s1_unexpected_rdv");
        else begin
          check("s1_data", s1_rdata, exp_d1.pop_front());
          check("s1_latency", cyc - acc_cyc, exp_lat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    adr[0] = '0;
    adr[1] = '0;

    // reset values
    #3;
    check("rst_m_read", m_read, 0);
    check("rst_m_lock", m_lock, 0);
    check("rst_m_address", m_address, 0);
    check("rst_s0_rdv", s0_rdv, 0);
    check("rst_s1_rdv", s1_rdv, 0);
    check("rst_s0_rdata", s0_rdata, 0);
    check("rst_s1_rdata", s1_rdata, 0);
    check("rst_s0_wait", s0_wait, 0);
    #20;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // port 0 alone, data 4 cycles after accept
    ws = 0; lat = 4; same = 1'b0;
    exp_a.push_back(27'h0000100);
    issue(0, 27'h0000100, 1'b0, 32'hDEADBEEF);
    rd[0] = 1'b0;
    idle(3);
    check("s1_untouched", s1_rdata, 0);

    // accept and data in the same cycle
    ws = 1; same = 1'b1;
    exp_a.push_back(27'h0200010);
    issue(1, 27'h0200010, 1'b0, 32'h12345678);
    rd[1] = 1'b0;
    idle(3);
    ws = 0; same = 1'b0; lat = 2;

    // both ports requesting continuously
`ifdef AUDIO_PRIORITY_EN
    exp_a.push_back(27'h0200000); exp_a.push_back(27'h0200004);
    exp_a.push_back(27'h0000200); exp_a.push_back(27'h0000204);
`else
    exp_a.push_back(27'h0000200); exp_a.push_back(27'h0200000);
    exp_a.push_back(27'h0000204); exp_a.push_back(27'h0200004);
`endif
    fork
      begin
        issue(0, 27'h0000200, 1'b0, 32'h00000A00);
        issue(0, 27'h0000204, 1'b0, 32'h00000A04);
        rd[0] = 1'b0;
      end
      begin
        issue(1, 27'h0200000, 1'b0, 32'h00001B00);
        issue(1, 27'h0200004, 1'b0, 32'h00001B04);
        rd[1] = 1'b0;
      end
    join
    idle(3);

    // port 1 locked five times, port 0 pending from the second cycle
    exp_a.push_back(27'h0200100); exp_a.push_back(27'h0200104);
    exp_a.push_back(27'h0200108); exp_a.push_back(27'h020010C);
`ifdef AUDIO_PRIORITY_EN
    exp_a.push_back(27'h0200110); exp_a.push_back(27'h0000300);
`else
    exp_a.push_back(27'h0000300); exp_a.push_back(27'h0200110);
`endif
    fork
      begin
        for (int i = 0; i < 5; i++)
          issue(1, 27'h0200100 + 27'(4 * i), 1'b1, 32'h11000000 + 32'(i));
        rd[1] = 1'b0;
        lk[1] = 1'b0;
      end
      begin
        idle(1);
        issue(0, 27'h0000300, 1'b0, 32'h5A5A0300);
        rd[0] = 1'b0;
      end
    join
    idle(3);

    // port 0 abandons during DATA
    lat = 4;
    exp_a.push_back(27'h0000400);
    adr[0] = 27'h0000400;
    mem[27'h0000400] = 32'hBAD0BAD0;
    rd[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (m_read && !m_wait) seen = 1'b1;
    end
    check("abandon_accepted", seen, 1);
    @(posedge clock);
    #1;
    rd[0] = 1'b0;
    idle(8);
    check("s0_rdata_hold", s0_rdata, 32'h5A5A0300);
    exp_a.push_back(27'h0200200);
    issue(1, 27'h0200200, 1'b0, 32'hCAFEF00D);
    rd[1] = 1'b0;
    idle(3);

    // asynchronous reset while the command is stalled in ISSUE
    ws = 20;
    adr[0] = 27'h0000500;
    lk[0]  = 1'b1;
    rd[0]  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (m_read) seen = 1'b1;
    end
    check("pre_reset_m_lock", m_lock, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_m_read", m_read, 0);
    check("arst_m_lock", m_lock, 0);
    check("arst_m_address", m_address, 0);
    check("arst_s0_rdata", s0_rdata, 0);
    check("arst_s1_rdata", s1_rdata, 0);
    check("arst_s0_rdv", s0_rdv, 0);
    rd[0] = 1'b0;
    lk[0] = 1'b0;
    idle(3);
    @(negedge clock);
    reset_n = 1'b1;
    ws = 0; lat = 3;
    @(posedge clock);
    #1;
    exp_a.push_back(27'h0000600);
    issue(0, 27'h0000600, 1'b0, 32'hA5A5A5A5);
    rd[0] = 1'b0;
    idle(3);

`ifdef AUDIO_PRIORITY_EN
    // simultaneous tie goes to port 1
    lat = 2;
    exp_a.push_back(27'h0200300);
    exp_a.push_back(27'h0000700);
    fork
      begin
        issue(0, 27'h0000700, 1'b0, 32'h07000700);
        rd[0] = 1'b0;
      end
      begin
        issue(1, 27'h0200300, 1'b0, 32'h13001300);
        rd[1] = 1'b0;
      end
    join
    idle(3);
`endif

    idle(5);
    check("exp_a_drained", exp_a.size(), 0);
    check("exp_d0_drained", exp_d0.size(), 0);
    check("exp_d1_drained", exp_d1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
